// File: rtl/axi2regs_bank.sv
// Register bank behind an axi2regs stage: eight 32-bit words with RW, RO, WO,
// and W1C registers, a command pulse port, a level interrupt and a free-running timestamp.
module axi2regs_bank #(
  parameter logic [31:0] VERSION = 32'h0001_0100,
  parameter int          ADDR_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] reg_wr_addr,
  input  logic [31:0]       reg_wr_data,
  input  logic [3:0]        reg_wr_strb,
  input  logic              reg_rd_en,
  input  logic [ADDR_W-1:0] reg_rd_addr,
  output logic [31:0]       reg_rd_data,
  output logic              reg_rd_valid,
  output logic              reg_rd_err,
  output logic              reg_wr_err,
  input  logic [7:0]        hw_event,
  output logic [31:0]       ctrl0,
  output logic [31:0]       ctrl1,
  output logic [7:0]        cmd_pulse,
  output logic              irq,
  output logic [31:0]       timestamp
);

  localparam logic [2:0] IDX_VERSION = 3'd0;
  localparam logic [2:0] IDX_SCRATCH = 3'd1;
  localparam logic [2:0] IDX_CTRL0   = 3'd2;
  localparam logic [2:0] IDX_CTRL1   = 3'd3;
  localparam logic [2:0] IDX_CMD     = 3'd4;
  localparam logic [2:0] IDX_STATUS  = 3'd5;
  localparam logic [2:0] IDX_IRQ_EN  = 3'd6;
  localparam logic [2:0] IDX_TSTAMP  = 3'd7;

  logic [31:0] r_scratch, r_ctrl0, r_ctrl1, r_timestamp;
  logic [31:0] r_rd_data;
  logic [7:0]  r_status, r_irq_en, r_cmd_pulse;
  logic        r_rd_valid, r_rd_err, r_wr_err, r_irq;

  logic        w_wr_mapped, w_rd_mapped;
  logic [2:0]  w_wr_idx, w_rd_idx;
  logic [7:0]  w_wr_sel;
  logic [7:0]  w_status_clr, w_status_nxt;
  logic [31:0] w_rd_val;
  logic        w_unused_addr_bits;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    return res;
  endfunction

  // Only word index [4:2] is decoded; any set bit above it makes the address unmapped.
  assign w_wr_mapped = (reg_wr_addr[ADDR_W-1:5] == '0);
  assign w_rd_mapped = (reg_rd_addr[ADDR_W-1:5] == '0);
  assign w_wr_idx    = reg_wr_addr[4:2];
  assign w_rd_idx    = reg_rd_addr[4:2];
  assign w_wr_sel    = (reg_wr_en && w_wr_mapped) ? (8'd1 << w_wr_idx) : 8'd0;
  assign w_unused_addr_bits = ^{reg_wr_addr[1:0], reg_rd_addr[1:0]};

  // A hardware set wins over a simultaneous software clear.
  assign w_status_clr = (w_wr_sel[IDX_STATUS] && reg_wr_strb[0]) ? reg_wr_data[7:0] : 8'd0;
  assign w_status_nxt = (r_status & ~w_status_clr) | hw_event;

  always_comb begin
    w_rd_val = 32'hDEAD_BEEF;
    if (w_rd_mapped) begin
      case (w_rd_idx)
        IDX_VERSION: w_rd_val = VERSION;
        IDX_SCRATCH: w_rd_val = r_scratch;
        IDX_CTRL0:   w_rd_val = r_ctrl0;
        IDX_CTRL1:   w_rd_val = r_ctrl1;
        IDX_CMD:     w_rd_val = 32'd0;
        IDX_STATUS:  w_rd_val = {24'd0, r_status};
        IDX_IRQ_EN:  w_rd_val = {24'd0, r_irq_en};
        default:     w_rd_val = r_timestamp;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_scratch   <= '0;
      r_ctrl0     <= '0;
      r_ctrl1     <= '0;
      r_status    <= '0;
      r_irq_en    <= '0;
      r_timestamp <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_err    <= 1'b0;
      r_wr_err    <= 1'b0;
      r_cmd_pulse <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_sel[IDX_SCRATCH]) r_scratch <= apply_strb(r_scratch, reg_wr_data, reg_wr_strb);
      if (w_wr_sel[IDX_CTRL0])   r_ctrl0   <= apply_strb(r_ctrl0, reg_wr_data, reg_wr_strb);
      if (w_wr_sel[IDX_CTRL1])   r_ctrl1   <= apply_strb(r_ctrl1, reg_wr_data, reg_wr_strb);
      if (w_wr_sel[IDX_IRQ_EN] && reg_wr_strb[0]) r_irq_en <= reg_wr_data[7:0];
      r_status    <= w_status_nxt;
      r_cmd_pulse <= (w_wr_sel[IDX_CMD] && reg_wr_strb[0]) ? reg_wr_data[7:0] : 8'd0;
      r_wr_err    <= reg_wr_en && !w_wr_mapped;
      r_irq       <= |(r_status & r_irq_en);

      if (r_cmd_pulse[7])  r_timestamp <= '0;
      else if (r_ctrl0[31]) r_timestamp <= r_timestamp + 32'd1;

      // Read samples pre-write register state, so same-address read/write returns the old value.
      r_rd_valid <= reg_rd_en;
      r_rd_err   <= reg_rd_en && !w_rd_mapped;
      if (reg_rd_en) r_rd_data <= w_rd_val;
    end
  end

  assign reg_rd_data  = r_rd_data;
  assign reg_rd_valid = r_rd_valid;
  assign reg_rd_err   = r_rd_err;
  assign reg_wr_err   = r_wr_err;
  assign ctrl0        = r_ctrl0;
  assign ctrl1        = r_ctrl1;
  assign cmd_pulse    = r_cmd_pulse;
  assign irq          = r_irq;
  assign timestamp    = r_timestamp;

endmodule

// File: tb/tb_axi2regs_bank.sv
// Directed bench for axi2regs_bank: a vector table for plain register accesses
// plus hand-written sequences for STATUS/irq, timestamp, collisions and reset.
module tb_axi2regs_bank;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid, reg_rd_err, reg_wr_err;
  logic [7:0]  hw_event;
  logic [31:0] ctrl0, ctrl1, timestamp;
  logic [7:0]  cmd_pulse;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  axi2regs_bank #(.VERSION(32'h0001_0100), .ADDR_W(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid), .reg_rd_err(reg_rd_err),
    .reg_wr_err(reg_wr_err), .hw_event(hw_event), .ctrl0(ctrl0), .ctrl1(ctrl1),
    .cmd_pulse(cmd_pulse), .irq(irq), .timestamp(timestamp)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Tasks start at a falling edge and return at the next one with strobes dropped.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d; reg_wr_strb = s;
    @(negedge ACLK);
    reg_wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    reg_rd_en = 1'b1; reg_rd_addr = a;
    @(negedge ACLK);
    reg_rd_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    do_read(a);
    check({name, "_valid"}, {31'd0, reg_rd_valid}, 32'd1);
    check({name, "_data"}, reg_rd_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0; reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0;
    reg_rd_en = 1'b0; reg_rd_addr = '0; hw_event = 8'hFF;

    //             wr    addr   data           strb  exp            err
    tbl.push_back({1'b0, 8'h00, 32'h0,         4'h0, 32'h0001_0100, 1'b0});
    tbl.push_back({1'b1, 8'h04, 32'h1,         4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b1, 8'h08, 32'h2,         4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b1, 8'h0C, 32'h3,         4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b1, 8'h18, 32'h4,         4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b0, 8'h04, 32'h0,         4'h0, 32'h1,         1'b0});
    tbl.push_back({1'b0, 8'h08, 32'h0,         4'h0, 32'h2,         1'b0});
    tbl.push_back({1'b0, 8'h0C, 32'h0,         4'h0, 32'h3,         1'b0});
    tbl.push_back({1'b0, 8'h18, 32'h0,         4'h0, 32'h4,         1'b0});
    tbl.push_back({1'b1, 8'h04, 32'h11223344,  4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b1, 8'h05, 32'hAABBCCDD,  4'h5, 32'h0,         1'b0});
    tbl.push_back({1'b0, 8'h07, 32'h0,         4'h0, 32'h11BB33DD,  1'b0});
    tbl.push_back({1'b0, 8'h20, 32'h0,         4'h0, 32'hDEADBEEF,  1'b1});
    tbl.push_back({1'b1, 8'h20, 32'hFFFFFFFF,  4'hF, 32'h0,         1'b1});
    tbl.push_back({1'b0, 8'h04, 32'h0,         4'h0, 32'h11BB33DD,  1'b0});
    tbl.push_back({1'b1, 8'h00, 32'h12345678,  4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b1, 8'h1C, 32'h12345678,  4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b0, 8'h00, 32'h0,         4'h0, 32'h0001_0100, 1'b0});
    tbl.push_back({1'b0, 8'h10, 32'h0,         4'h0, 32'h0,         1'b0});
    tbl.push_back({1'b1, 8'h18, 32'hFFFFFFFF,  4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b0, 8'h18, 32'h0,         4'h0, 32'hFF,        1'b0});
    tbl.push_back({1'b1, 8'h18, 32'h0,         4'hF, 32'h0,         1'b0});
    tbl.push_back({1'b0, 8'hFC, 32'h0,         4'h0, 32'hDEADBEEF,  1'b1});

    // Reset with hw_event held high: nothing may stick.
    repeat (3) @(negedge ACLK);
    check("rst_rd_valid", {31'd0, reg_rd_valid}, 32'd0);
    check("rst_rd_data", reg_rd_data, 32'd0);
    check("rst_wr_err", {31'd0, reg_wr_err}, 32'd0);
    check("rst_cmd_pulse", {24'd0, cmd_pulse}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ctrl0", ctrl0, 32'd0);
    check("rst_ctrl1", ctrl1, 32'd0);
    check("rst_timestamp", timestamp, 32'd0);
    ARESETN = 1'b1; hw_event = 8'h00;
    read_check("rst_status", 8'h14, 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        check($sformatf("vec%0d_wr_err", i), {31'd0, reg_wr_err}, {31'd0, tbl[i].exp_err});
      end else begin
        do_read(tbl[i].addr);
        check($sformatf("vec%0d_valid", i), {31'd0, reg_rd_valid}, 32'd1);
        check($sformatf("vec%0d_data", i), reg_rd_data, tbl[i].exp);
        check($sformatf("vec%0d_rd_err", i), {31'd0, reg_rd_err}, {31'd0, tbl[i].exp_err});
      end
    end
    @(negedge ACLK);
    check("valid_single_pulse", {31'd0, reg_rd_valid}, 32'd0);
    check("wr_err_single_pulse", {31'd0, reg_wr_err}, 32'd0);
    check("ctrl0_port", ctrl0, 32'h2);
    check("ctrl1_port", ctrl1, 32'h3);

    // Same-address read and write in one cycle returns the pre-write value.
    reg_rd_en = 1'b1; reg_rd_addr = 8'h04;
    do_write(8'h04, 32'h0000_0055, 4'hF);
    reg_rd_en = 1'b0;
    check("collide_data", reg_rd_data, 32'h11BB33DD);
    read_check("collide_after", 8'h04, 32'h55);

    // STATUS set/clear and irq latency.
    do_write(8'h18, 32'h01, 4'hF);
    hw_event = 8'h01;
    @(negedge ACLK);
    hw_event = 8'h00;
    check("irq_latency", {31'd0, irq}, 32'd0);
    @(negedge ACLK);
    check("irq_set", {31'd0, irq}, 32'd1);
    read_check("status_set", 8'h14, 32'h01);
    hw_event = 8'h01;
    do_write(8'h14, 32'h01, 4'h1);
    hw_event = 8'h00;
    read_check("status_set_wins", 8'h14, 32'h01);
    do_write(8'h14, 32'hFF, 4'hE);
    read_check("status_strb0_off", 8'h14, 32'h01);
    do_write(8'h14, 32'h01, 4'h1);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge ACLK);
    check("irq_clear", {31'd0, irq}, 32'd0);
    read_check("status_cleared", 8'h14, 32'h0);

    // Timestamp run, then clear via cmd_pulse[7].
    do_write(8'h08, 32'h8000_0000, 4'hF);
    repeat (10) @(negedge ACLK);
    read_check("ts_first", 8'h1C, 32'd10);
    read_check("ts_second", 8'h1C, 32'd11);
    do_write(8'h10, 32'h80, 4'h1);
    check("cmd_pulse_on", {24'd0, cmd_pulse}, 32'h80);
    check("ts_before_clr", timestamp, 32'd13);
    @(negedge ACLK);
    check("cmd_pulse_off", {24'd0, cmd_pulse}, 32'h0);
    check("ts_cleared", timestamp, 32'd0);
    read_check("ts_restart", 8'h1C, 32'd0);
    do_write(8'h10, 32'h3C, 4'h0);
    check("cmd_strb_masked", {24'd0, cmd_pulse}, 32'h0);

    // Reset during a read: the in-flight read is dropped.
    do_write(8'h0C, 32'hCAFE_F00D, 4'hF);
    ARESETN = 1'b0; reg_rd_en = 1'b1; reg_rd_addr = 8'h0C;
    @(negedge ACLK);
    ARESETN = 1'b1; reg_rd_en = 1'b0;
    check("rst_drop_valid0", {31'd0, reg_rd_valid}, 32'd0);
    @(negedge ACLK);
    check("rst_drop_valid1", {31'd0, reg_rd_valid}, 32'd0);
    check("rst2_ctrl0", ctrl0, 32'd0);
    read_check("rst2_scratch", 8'h04, 32'h0);
    read_check("rst2_ctrl0_rd", 8'h08, 32'h0);
    read_check("rst2_ctrl1_rd", 8'h0C, 32'h0);
    read_check("rst2_status", 8'h14, 32'h0);
    read_check("rst2_irq_en", 8'h18, 32'h0);
    read_check("rst2_ts", 8'h1C, 32'h0);
    read_check("rst2_version", 8'h00, 32'h0001_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
